// File: rtl/gap_expand_layer.sv
// Broadcast expander: one accepted word is scaled per channel and replayed OUTPUT_SIZE times; first word 1 cycle after accept.
// Backpressure: output word and count hold while ready_i is low; a new input is taken only in idle or on the final transfer.
module gap_expand_layer #(
    parameter int OUTPUT_SIZE  = 4,
    parameter int WORD_SIZE    = 16,
    parameter int N_SIZE       = 12,
    parameter int NUM_CHANNELS = 1,
    parameter int MULTIPLIER   = 1024
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    output logic                              ready_o,
    input  logic                              valid_i,
    input  logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_o,
    output logic                              last_o
);

    localparam int CW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int DW = NUM_CHANNELS * WORD_SIZE;
    localparam int PW = 2 * WORD_SIZE;
    localparam logic [CW-1:0]               LAST_CNT = CW'(OUTPUT_SIZE - 1);
    localparam logic signed [WORD_SIZE-1:0] MULT     = WORD_SIZE'(MULTIPLIER);
    localparam logic signed [PW-1:0]        R_MAX    = {{(WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [PW-1:0]        R_MIN    = {{(WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};
    localparam logic [WORD_SIZE-1:0]        SAT_POS  = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0]        SAT_NEG  = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic {
        eIDLE,
        eEMIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   scaled;
    logic            last_w;
    logic            accept;
    logic            xfer;

    // Full-width signed product, floor shift back to Qm.n, then clamp per channel.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shr;

        assign prod = PW'($signed(data_r_i[c*WORD_SIZE +: WORD_SIZE])) * PW'(MULT);
        assign shr  = prod >>> N_SIZE;
        assign scaled[c*WORD_SIZE +: WORD_SIZE] = (shr > R_MAX) ? SAT_POS :
                                                  (shr < R_MIN) ? SAT_NEG :
                                                  shr[WORD_SIZE-1:0];
    end

    assign last_w   = (state_q == eEMIT) && (count_q == LAST_CNT);
    assign ready_o  = (state_q == eIDLE) || (last_w && ready_i);
    assign accept   = valid_i && ready_o;
    assign xfer     = (state_q == eEMIT) && ready_i;
    assign valid_o  = (state_q == eEMIT);
    assign last_o   = last_w;
    assign data_r_o = data_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            eIDLE: begin
                if (accept) begin
                    data_d  = scaled;
                    count_d = '0;
                    state_d = eEMIT;
                end
            end
            eEMIT: begin
                if (xfer) begin
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        if (accept) begin
                            data_d = scaled;
                        end else begin
                            state_d = eIDLE;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule
